causal_conv_mac: RTL and testbench
==================================

Name: causal_conv_mac

Overview:
Downstream consumer of the kernel-4 activation cache. It takes one 4-tap window of signed Q(W-FRAC).FRAC samples, computes the dot product with four programmable weights plus a bias, then rescales, saturates and optionally applies ReLU. It uses one shared multiplier over 4 MAC cycles and has valid/ready handshakes on both sides. The output feeds the next layer's activation cache.

Parameters:
W, 16, width of taps, weights, bias and result (signed two's complement)
FRAC, 12, fractional bits of every W-bit quantity (default Q4.12, 1.0 = 4096)
RELU, 0, 1 = clamp negative results to 0 after saturation
ACC_W, 2*W+3, accumulator width (signed); sized so 4 products plus bias cannot overflow

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  tap window present
in_ready  out  1  block can accept a window
tap  in  W x 4 (signed array [0:3])  tap[0] oldest (t-3D) ... tap[3] current sample
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out  out  W signed  result
wt_we  in  1  coefficient write strobe
wt_addr  in  3  0..3 = weight w[k]; 4 = bias; 5..7 reserved
wt_data  in  W signed  coefficient value
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; acc=0; out=0; out_valid=0; w[0..3]=0; bias=0; captured taps=0; k=0. in_ready=0 while rst=0.
- in_ready = (state==IDLE) && rst. out_valid is high only in state OUT.
- FSM states: IDLE, MAC, FINISH, OUT.
  - IDLE: on in_valid && in_ready, register tap[0..3], set acc = sign_ext(bias) << FRAC, set k=0, go to MAC.
  - MAC: each cycle acc += tapq[k]*w[k] (full 2W-bit signed product, sign-extended to ACC_W). k increments; after the k=3 cycle, go to FINISH. Exactly 4 MAC cycles.
  - FINISH: r = acc >>> FRAC (arithmetic shift, truncation toward -inf). Saturate r to [-2^(W-1), 2^(W-1)-1]. If RELU=1 and the saturated value < 0, the value becomes 0. Register the value into out and go to OUT.
  - OUT: hold out and out_valid stable until out_ready=1, then go to IDLE. out keeps its last value after the handshake; out_valid drops.
- Latency: acceptance edge E0; MAC edges E1..E4; FINISH edge E5; out_valid is high from E5. Minimum initiation interval is 7 cycles: output handshake at E6 returns to IDLE, next accept at E7.
- Backpressure:
  - out_ready low holds OUT indefinitely with out stable.
  - in_valid is ignored while in_ready=0. The upstream stage must hold its window.
- in_valid and out_ready may both be high in OUT. Only the output handshake happens that cycle; the input is accepted in the next IDLE cycle.
- Coefficient writes:
  - wt_we is honoured only when state==IDLE; the value updates on that edge. If a write and an input accept occur on the same IDLE edge, the new weight is used for that window. A bias write on that same edge is not used for that window, because acc is loaded with the old bias.
  - wt_we while busy is dropped with no side effect.
  - wt_addr 5..7 is ignored.
- Reset mid-operation aborts the in-flight window: no output is produced and coefficients are cleared to 0.
- Taps and coefficients are sampled only as specified above. Input changes at other times have no effect.

Test Plan:
1. Basic dot product: w=[4096,4096,4096,4096], bias=0, taps=[4096,8192,-4096,0] -> out=8192, out_valid high exactly 5 edges after acceptance.
2. Bias and truncation: w=[1,0,0,0], bias=0, tap[0]=1 -> out=0; tap[0]=-1 -> out=-1. Then bias=4096 with all taps=0 -> out=4096.
3. Saturation: all w=32767, all taps=32767 -> out=32767. tap[0..3]=-32768 with w=32767 -> out=-32768. With RELU=1, the second case -> out=0.
4. Backpressure: hold out_ready=0 for 10 cycles in OUT -> out, out_valid stable; in_ready=0; a concurrent second window is not accepted until after the handshake and the return to IDLE.
5. Coefficient gating: write w[0]=8192 during MAC -> ignored (result uses the old w[0]). The same write in IDLE is applied to the next window.
6. Reset mid-MAC: assert rst=0 at E2 -> out_valid=0, out=0, all coefficients read back as 0 effect (next window with no writes -> out=0). in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/causal_conv_mac.sv
// Kernel-4 causal convolution MAC: one shared multiplier accumulates four tap*weight
// products onto a bias, then rescales, saturates and optionally clamps with ReLU.
module causal_conv_mac #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int RELU  = 0,
  parameter int ACC_W = 2*W+3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] tap [0:3],
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out,
  input  logic                wt_we,
  input  logic [2:0]          wt_addr,
  input  logic signed [W-1:0] wt_data,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a presented window/result is held until transferred.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_FINISH = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t                r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [W-1:0]   r_out;
  logic signed [W-1:0]   r_w     [0:3];
  logic signed [W-1:0]   r_bias;
  logic signed [W-1:0]   r_tapq  [0:3];
  logic [1:0]            r_k;

  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [W-1:0]     w_sat;
  logic signed [W-1:0]     w_res;

  assign w_prod     = r_tapq[r_k] * r_w[r_k];
  assign w_prod_ext = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-W){r_bias[W-1]}}, r_bias} << FRAC;
  // Arithmetic shift: rounds toward -inf, so small negative values become -1.
  assign w_shift    = r_acc >>> FRAC;

  always_comb begin
    w_sat = w_shift[W-1:0];
    if (w_shift > SAT_MAX)      w_sat = {1'b0, {(W-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_sat = {1'b1, {(W-1){1'b0}}};
    w_res = w_sat;
    if (RELU != 0 && w_sat[W-1]) w_res = '0;
  end

  assign in_ready  = (r_state == S_IDLE) && rst;
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out       = r_out;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_out   <= '0;
      r_bias  <= '0;
      r_k     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_w[i]    <= '0;
        r_tapq[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // Weights are read only in MAC, so a same-edge weight write reaches this window;
          // the accumulator is seeded from the bias held before this edge.
          if (wt_we) begin
            if (!wt_addr[2])          r_w[wt_addr[1:0]] <= wt_data;
            else if (wt_addr == 3'd4) r_bias            <= wt_data;
          end
          if (in_valid) begin
            for (int i = 0; i < 4; i++) r_tapq[i] <= tap[i];
            r_acc   <= w_bias_ext;
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_out   <= w_res;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_causal_conv_mac.sv
// Bench for causal_conv_mac: directed and random windows against an arithmetic model,
// with a ReLU instance driven in lockstep from the same inputs.
module tb_causal_conv_mac;
  localparam int W    = 16;
  localparam int FRAC = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic                wt_we = 1'b0;
  logic [2:0]          wt_addr = 3'd0;
  logic signed [W-1:0] wt_data = '0;
  logic signed [W-1:0] tap [0:3];

  logic                in_ready, out_valid, busy;
  logic signed [W-1:0] out;
  logic [1:0]          dbg_state;
  logic                r_in_ready, r_out_valid, r_busy;
  logic signed [W-1:0] r_out;
  logic [1:0]          r_dbg_state;

  causal_conv_mac #(.W(W), .FRAC(FRAC), .RELU(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .tap(tap),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .busy(busy), .dbg_state(dbg_state)
  );

  causal_conv_mac #(.W(W), .FRAC(FRAC), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .tap(tap),
    .out_valid(r_out_valid), .out_ready(out_ready), .out(r_out), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .busy(r_busy), .dbg_state(r_dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int m_w [4];
  int m_bias;
  int cur_tap [4];

  task automatic check(string tag, longint obs, longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, floor-divide by 2^FRAC, clamp, optional ReLU.
  function automatic int model(bit relu);
    longint acc;
    acc = longint'(m_bias) * (longint'(1) << FRAC);
    for (int i = 0; i < 4; i++) acc += longint'(cur_tap[i]) * longint'(m_w[i]);
    acc = acc >>> FRAC;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(int a, int b, int c, int d);
    cur_tap[0] = a; cur_tap[1] = b; cur_tap[2] = c; cur_tap[3] = d;
    for (int i = 0; i < 4; i++) tap[i] = 16'(cur_tap[i]);
  endtask

  task automatic write_coef(int addr, int data);
    wt_we = 1'b1; wt_addr = 3'(addr); wt_data = 16'(data);
    tick();
    wt_we = 1'b0;
    if (addr < 4) m_w[addr] = data;
    else if (addr == 4) m_bias = data;
  endtask

  // Leaves the bench one step past the acceptance edge E0.
  task automatic start_window(bit we, int addr, int data);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    wt_we = we; wt_addr = 3'(addr); wt_data = 16'(data);
    tick();
    in_valid = 1'b0;
    wt_we = 1'b0;
  endtask

  task automatic wait_result(string tag, int exp0, int exp1, int already);
    int n = already;
    while (!out_valid && n < 40) begin tick(); n++; end
    check({tag, "_latency"}, n, 5);
    check({tag, "_out"}, out, exp0);
    check({tag, "_relu_out"}, r_out, exp1);
    check({tag, "_relu_valid"}, r_out_valid, 1);
  endtask

  task automatic handshake(int exp0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_drop", out_valid, 0);
    check("hs_out_hold", out, exp0);
  endtask

  task automatic run_window(string tag);
    int e0, e1;
    e0 = model(0);
    e1 = model(1);
    start_window(1'b0, 0, 0);
    wait_result(tag, e0, e1, 0);
    handshake(e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, eb1;
    for (int i = 0; i < 4; i++) m_w[i] = 0;
    m_bias = 0;
    set_taps(0, 0, 0, 0);

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_relu_in_ready", r_in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_relu_state", r_dbg_state, 0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Basic dot product
    for (int i = 0; i < 4; i++) write_coef(i, 4096);
    set_taps(4096, 8192, -4096, 0);
    start_window(1'b0, 0, 0);
    check("mac_busy", busy, 1);
    check("mac_in_ready", in_ready, 0);
    wait_result("basic", 8192, 8192, 0);
    handshake(8192);

    // Truncation toward -inf and bias
    write_coef(0, 1);
    for (int i = 1; i < 4; i++) write_coef(i, 0);
    set_taps(1, 0, 0, 0);
    start_window(1'b0, 0, 0); wait_result("trunc_pos", 0, 0, 0); handshake(0);
    set_taps(-1, 0, 0, 0);
    start_window(1'b0, 0, 0); wait_result("trunc_neg", -1, 0, 0); handshake(-1);
    write_coef(4, 4096);
    set_taps(0, 0, 0, 0);
    start_window(1'b0, 0, 0); wait_result("bias", 4096, 4096, 0); handshake(4096);

    // Saturation both ways, ReLU clamp on the negative case
    write_coef(4, 0);
    for (int i = 0; i < 4; i++) write_coef(i, 32767);
    set_taps(32767, 32767, 32767, 32767);
    start_window(1'b0, 0, 0); wait_result("sat_pos", 32767, 32767, 0); handshake(32767);
    set_taps(-32768, -32768, -32768, -32768);
    start_window(1'b0, 0, 0); wait_result("sat_neg", -32768, 0, 0); handshake(-32768);

    // Backpressure with a second window waiting
    for (int i = 0; i < 4; i++) write_coef(i, 4096);
    set_taps(100, 200, 300, 400);
    ea = model(0);
    start_window(1'b0, 0, 0);
    wait_result("bp_first", ea, ea, 0);
    set_taps(-50, 0, 0, 0);
    eb = model(0); eb1 = model(1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_stable", out, ea);
      check("bp_valid_stable", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_valid_drop", out_valid, 0);
    check("bp_hs_idle", busy, 0);
    check("bp_hs_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_second_accepted", busy, 1);
    wait_result("bp_second", eb, eb1, 0);
    handshake(eb);

    // Coefficient write during MAC is dropped; in IDLE it applies
    set_taps(4096, 0, 0, 0);
    start_window(1'b0, 0, 0);
    wt_we = 1'b1; wt_addr = 3'd0; wt_data = 16'(8192);
    tick();
    wt_we = 1'b0;
    wait_result("gate_busy", 4096, 4096, 1);
    handshake(4096);
    write_coef(0, 8192);
    start_window(1'b0, 0, 0); wait_result("gate_idle", 8192, 8192, 0); handshake(8192);

    // Writes on the acceptance edge: weight takes effect, bias does not
    set_taps(0, 4096, 0, 0);
    m_w[1] = 8192;
    start_window(1'b1, 1, 8192); wait_result("same_edge_w", 8192, 8192, 0); handshake(8192);
    set_taps(0, 0, 0, 0);
    start_window(1'b1, 4, 4096); wait_result("same_edge_bias", 0, 0, 0); handshake(0);
    m_bias = 4096;
    start_window(1'b0, 0, 0); wait_result("bias_after", 4096, 4096, 0); handshake(4096);

    // Reserved address is ignored
    write_coef(5, 1234);
    run_window("reserved_addr");

    // Random windows with random consumer stalls
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 4; i++)
        write_coef(i, (it % 2 == 0) ? rnd16() : int'($urandom_range(0, 8191)) - 4096);
      write_coef(4, rnd16());
      set_taps(rnd16(), rnd16(), rnd16(), rnd16());
      ea = model(0); eb1 = model(1);
      start_window(1'b0, 0, 0);
      wait_result("rand", ea, eb1, 0);
      repeat ($urandom_range(0, 3)) tick();
      handshake(ea);
    end

    // Reset in the middle of MAC aborts the window and clears coefficients
    for (int i = 0; i < 4; i++) write_coef(i, 4096);
    set_taps(4096, 4096, 4096, 4096);
    start_window(1'b0, 0, 0);
    tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_relu_out", r_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_relu_busy", r_busy, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) m_w[i] = 0;
    m_bias = 0;
    start_window(1'b0, 0, 0); wait_result("post_rst", 0, 0, 0); handshake(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
